// File: rtl/sonar_pkg.sv
// Shared constants and FSM encoding for the round-robin HC-SR04 sonar scheduler.
package sonar_pkg;
  localparam int NUM_SENSORS            = 3;
  localparam int TRIG_CYCLES_DEF        = 500;
  localparam int CYCLES_PER_CM_DEF      = 2900;
  localparam int TIMEOUT_CYCLES_DEF     = 1500000;
  localparam int GUARD_CYCLES_DEF       = 750000;
  localparam int DIST_W_DEF             = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_ECHO,
    ST_MEASURE,
    ST_GUARD
  } state_e;
endpackage

// File: rtl/sonar_scheduler_echo_sync_edge.sv
// Two-flop synchronizer for one raw echo pin followed by a registered rise/fall detector.
module echo_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic echo_i,
  output logic rise_o,
  output logic fall_o
);
  logic meta_q, sync_q, prev_q, rise_q, fall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= echo_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
      fall_q <= ~sync_q & prev_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

// File: rtl/sonar_scheduler.sv
// Round-robin trigger/echo sequencer for three sonar sensors; converts echo width to whole cm.
module sonar_scheduler
  import sonar_pkg::*;
#(
  parameter int TRIG_CYCLES    = TRIG_CYCLES_DEF,
  parameter int CYCLES_PER_CM  = CYCLES_PER_CM_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int GUARD_CYCLES   = GUARD_CYCLES_DEF,
  parameter int DIST_W         = DIST_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_SENSORS-1:0] echo,
  output logic [NUM_SENSORS-1:0] trig,
  output logic [DIST_W-1:0]      distance1,
  output logic [DIST_W-1:0]      distance2,
  output logic [DIST_W-1:0]      distance3,
  output logic [NUM_SENSORS-1:0] valid,
  output logic [NUM_SENSORS-1:0] timeout,
  output logic [1:0]             active,
  output logic                   busy
);
  localparam int CNT_MAX0 = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES;
  localparam int CNT_MAX  = (CNT_MAX0 > TRIG_CYCLES) ? CNT_MAX0 : TRIG_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int SUB_W    = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;
  localparam logic [DIST_W-1:0] DIST_MAX = '1;

  logic [NUM_SENSORS-1:0] rise_w, fall_w;

  for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_echo
    echo_sync_edge u_sync (
      .clk    (clk),
      .rst    (reset),
      .echo_i (echo[g]),
      .rise_o (rise_w[g]),
      .fall_o (fall_w[g])
    );
  end

  state_e                              state_q, state_d;
  logic [1:0]                          active_q, active_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [SUB_W-1:0]                    sub_q, sub_d;
  logic [DIST_W-1:0]                   cm_q, cm_d, cm_inc;
  logic [NUM_SENSORS-1:0][DIST_W-1:0]  dist_q, dist_d;
  logic [NUM_SENSORS-1:0]              valid_q, valid_d, tflag_q, tflag_d;
  logic                                rise_sel, fall_sel, sub_wrap;

  assign rise_sel = rise_w[active_q];
  assign fall_sel = fall_w[active_q];
  assign sub_wrap = (sub_q == SUB_W'(CYCLES_PER_CM - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      active_q <= '0;
      cnt_q    <= '0;
      sub_q    <= '0;
      cm_q     <= '0;
      dist_q   <= '0;
      valid_q  <= '0;
      tflag_q  <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      sub_q    <= sub_d;
      cm_q     <= cm_d;
      dist_q   <= dist_d;
      valid_q  <= valid_d;
      tflag_q  <= tflag_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    sub_d    = sub_q;
    cm_d     = cm_q;
    dist_d   = dist_q;
    valid_d  = '0;
    tflag_d  = tflag_q;
    // cm count including the current cycle, so the published value covers every high cycle
    cm_inc   = cm_q;
    if (sub_wrap && cm_q != DIST_MAX) cm_inc = cm_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_TRIG;
          cnt_d   = '0;
        end
      end
      ST_TRIG: begin
        if (cnt_q == CNT_W'(TRIG_CYCLES - 1)) begin
          state_d = ST_WAIT_ECHO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_ECHO, ST_MEASURE: begin
        // a falling edge beats a simultaneous timeout
        if (state_q == ST_MEASURE && fall_sel) begin
          dist_d[active_q]  = cm_inc;
          valid_d[active_q] = 1'b1;
          tflag_d[active_q] = 1'b0;
          state_d           = ST_GUARD;
          cnt_d             = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          dist_d[active_q]  = DIST_MAX;
          valid_d[active_q] = 1'b1;
          tflag_d[active_q] = 1'b1;
          state_d           = ST_GUARD;
          cnt_d             = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (state_q == ST_WAIT_ECHO) begin
            if (rise_sel) begin
              state_d = ST_MEASURE;
              sub_d   = '0;
              cm_d    = '0;
            end
          end else begin
            sub_d = sub_wrap ? '0 : sub_q + 1'b1;
            cm_d  = cm_inc;
          end
        end
      end
      ST_GUARD: begin
        if (cnt_q == CNT_W'(GUARD_CYCLES - 1)) begin
          active_d = (active_q == 2'd2) ? 2'd0 : active_q + 1'b1;
          cnt_d    = '0;
          state_d  = enable ? ST_TRIG : ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign trig      = (state_q == ST_TRIG) ? (NUM_SENSORS'(1) << active_q) : '0;
  assign distance1 = dist_q[0];
  assign distance2 = dist_q[1];
  assign distance3 = dist_q[2];
  assign valid     = valid_q;
  assign timeout   = tflag_q;
  assign active    = active_q;
  assign busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_sonar_scheduler.sv
// Randomized bench for sonar_scheduler with scaled-down timing and a per-ping reference model.
module tb_sonar_scheduler;
  localparam int TRIG  = 5;
  localparam int CPM   = 10;
  localparam int TMO   = 1500;
  localparam int GUARD = 60;
  localparam int DW    = 7;
  localparam int MAXD  = (1 << DW) - 1;
  localparam int LIM   = 4000;

  logic          clk = 1'b0;
  logic          reset, enable;
  logic [2:0]    echo, trig, valid, timeout;
  logic [DW-1:0] distance1, distance2, distance3;
  logic [1:0]    active;
  logic          busy;

  int nvec = 0, nerr = 0;
  int cyc = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sonar_scheduler #(
    .TRIG_CYCLES(TRIG), .CYCLES_PER_CM(CPM), .TIMEOUT_CYCLES(TMO),
    .GUARD_CYCLES(GUARD), .DIST_W(DW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .echo(echo), .trig(trig),
    .distance1(distance1), .distance2(distance2), .distance3(distance3),
    .valid(valid), .timeout(timeout), .active(active), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] dist_of(input int s);
    case (s)
      0:       return distance1;
      1:       return distance2;
      default: return distance3;
    endcase
  endfunction

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_trig"}, trig, 0);
    chk({pfx, "_valid"}, valid, 0);
    chk({pfx, "_timeout"}, timeout, 0);
    chk({pfx, "_active"}, active, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_d1"}, distance1, 0);
    chk({pfx, "_d2"}, distance2, 0);
    chk({pfx, "_d3"}, distance3, 0);
  endtask

  // Invariant monitor: one-hot trig, trig width, dead time, distances change only with valid.
  initial begin
    logic [2:0]    trig_p;
    logic [DW-1:0] dist_p [3];
    int            rise_c, last_v;
    bit            have_v, en_ok;
    trig_p = '0; have_v = 0; en_ok = 0; rise_c = 0; last_v = 0;
    for (int i = 0; i < 3; i++) dist_p[i] = '0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0) begin
        trig_p = '0; have_v = 0;
        for (int i = 0; i < 3; i++) dist_p[i] = '0;
      end else begin
        if (trig != 0) chk("trig_onehot", 32'($onehot(trig)), 1);
        if (trig != 0 && trig_p == 0) begin
          rise_c = cyc;
          if (have_v) begin
            if (en_ok) chk("guard_gap", cyc - last_v, GUARD);
            else       chk("guard_min", 32'((cyc - last_v) >= GUARD), 1);
          end
        end
        if (trig == 0 && trig_p != 0) chk("trig_width", cyc - rise_c, TRIG);
        if (!enable) en_ok = 0;
        if (valid != 0) begin
          chk("valid_onehot", 32'($onehot(valid)), 1);
          last_v = cyc; have_v = 1; en_ok = enable;
        end
        for (int i = 0; i < 3; i++) begin
          if (dist_of(i) != dist_p[i]) chk("dist_hold", valid[i], 1);
          dist_p[i] = dist_of(i);
        end
        trig_p = trig;
      end
    end
  end

  // One measurement on sensor s: echo of width w (0 = no echo) starting dly cycles after trig falls.
  task automatic ping(input int s, input bit pre, input int dly, input int w, input bit drop);
    int n, fc, ed;
    bit et;
    if (pre) echo[s] = 1'b1;
    n = 0;
    while (trig == 0 && n < LIM) begin @(negedge clk); n++; end
    chk("trig_sel", trig, 32'(1 << s));
    chk("active", active, s);
    n = 0;
    while (trig != 0 && n < LIM) begin @(negedge clk); n++; end
    fc = cyc;
    repeat (dly) @(negedge clk);
    if (pre) begin echo[s] = 1'b0; repeat (5) @(negedge clk); end
    if (w > 0) begin
      echo[s] = 1'b1;
      repeat (w / 2) @(negedge clk);
      if (drop) enable = 1'b0;
      repeat (w - w / 2) @(negedge clk);
      echo[s] = 1'b0;
    end
    n = 0;
    while (valid == 0 && n < LIM) begin @(negedge clk); n++; end
    chk("valid_sel", valid, 32'(1 << s));
    et = (w == 0);
    ed = et ? MAXD : ((w / CPM > MAXD) ? MAXD : w / CPM);
    chk("distance", dist_of(s), ed);
    chk("timeout_flag", timeout[s], et);
    if (et) chk("timeout_lat", cyc - fc, TMO);
    @(negedge clk);
    chk("valid_pulse", valid, 0);
  endtask

  initial begin
    int n, w;
    reset = 1'b1; enable = 1'b0; echo = '0;
    repeat (5) @(negedge clk);
    chk_all_zero("rst");
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    enable = 1'b1;
    ping(0, 0, 3, 200, 0);

    // reset asserted 100 cycles into sensor 1's measurement
    n = 0;
    while (trig == 0 && n < LIM) begin @(negedge clk); n++; end
    chk("trig_sel", trig, 2);
    n = 0;
    while (trig != 0 && n < LIM) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    echo[1] = 1'b1;
    repeat (103) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_all_zero("rst_mid");
    @(negedge clk);
    echo = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // nominal round robin
    ping(0, 0, 3, 200, 0);
    ping(1, 0, 5, 400, 0);
    ping(2, 0, 2, 1000, 0);
    // quantisation
    ping(0, 0, 1, 9, 0);
    ping(1, 0, 1, 10, 0);
    ping(2, 0, 1, 19, 0);
    // timeout then recovery
    ping(0, 0, 4, 100, 0);
    ping(1, 0, 4, 250, 0);
    ping(2, 0, 0, 0, 0);
    ping(0, 0, 2, 300, 0);
    ping(1, 0, 2, 400, 0);
    ping(2, 0, 3, 100, 0);
    // echo stuck high before trigger
    ping(0, 1, 10, 100, 0);
    // saturation
    ping(1, 0, 2, 1400, 0);
    ping(2, 0, $urandom_range(0, 20), $urandom_range(1, 1300), 0);
    // random widths with occasional missing echo
    for (int k = 0; k < 9; k++) begin
      w = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 1300);
      ping(k % 3, 0, $urandom_range(0, 20), w, 0);
    end
    // enable dropped mid-measurement
    ping(0, 0, 2, 300, 1);
    repeat (GUARD + 10) @(negedge clk);
    chk("park_busy", busy, 0);
    chk("park_active", active, 1);
    enable = 1'b1;
    ping(1, 0, 2, 150, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
